// File: rtl/vscale_mem_arbiter.sv
// Shares one pipelined single-port memory between the fetch and data ports of vscale_core.
// Data port has address-phase priority; fetch is guaranteed a slot after MAX_DMEM_STREAK data grants.
module vscale_mem_arbiter #(
  parameter int MAX_DMEM_STREAK = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] imem_addr,
  output logic [31:0] imem_rdata,
  output logic        imem_wait,
  output logic        imem_badmem_e,
  input  logic        dmem_en,
  input  logic        dmem_wen,
  input  logic [2:0]  dmem_size,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata_delayed,
  output logic [31:0] dmem_rdata,
  output logic        dmem_wait,
  output logic        dmem_badmem_e,
  output logic        mem_en,
  output logic        mem_wen,
  output logic [2:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_wait,
  input  logic        mem_badmem_e
);

  localparam logic [3:0] MAX_STREAK = 4'(MAX_DMEM_STREAK);

  typedef enum logic [1:0] {
    OWNER_NONE,
    OWNER_IMEM,
    OWNER_DMEM
  } owner_t;

  owner_t      dp_owner_reg;
  logic        dp_wen_reg;
  logic [3:0]  streak_reg;
  logic        dmem_deferred_reg;

  // Copy of the last presented address phase, replayed while the memory stalls.
  logic        mem_en_reg;
  logic        mem_wen_reg;
  logic [2:0]  mem_size_reg;
  logic [31:0] mem_addr_reg;

  logic arb_active;
  logic grant_dmem;
  logic grant_imem;
  logic defer_dmem;

  assign arb_active = reset_n & ~mem_wait;
  assign grant_dmem = arb_active & dmem_en & (streak_reg < MAX_STREAK);
  assign defer_dmem = arb_active & dmem_en & (streak_reg >= MAX_STREAK);
  assign grant_imem = arb_active & ~grant_dmem;

  always_comb begin
    mem_en   = 1'b0;
    mem_wen  = 1'b0;
    mem_size = 3'b000;
    mem_addr = 32'h0;
    if (mem_wait) begin
      mem_en   = mem_en_reg;
      mem_wen  = mem_wen_reg;
      mem_size = mem_size_reg;
      mem_addr = mem_addr_reg;
    end else if (grant_dmem) begin
      mem_en   = 1'b1;
      mem_wen  = dmem_wen;
      mem_size = dmem_size;
      mem_addr = dmem_addr;
    end else if (grant_imem) begin
      mem_en   = 1'b1;
      mem_wen  = 1'b0;
      mem_size = 3'b010;
      mem_addr = imem_addr;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dp_owner_reg      <= OWNER_NONE;
      dp_wen_reg        <= 1'b0;
      streak_reg        <= 4'd0;
      dmem_deferred_reg <= 1'b0;
      mem_en_reg        <= 1'b0;
      mem_wen_reg       <= 1'b0;
      mem_size_reg      <= 3'b000;
      mem_addr_reg      <= 32'h0;
    end else if (!mem_wait) begin
      mem_en_reg        <= mem_en;
      mem_wen_reg       <= mem_wen;
      mem_size_reg      <= mem_size;
      mem_addr_reg      <= mem_addr;
      dp_wen_reg        <= mem_wen;
      dmem_deferred_reg <= defer_dmem;
      if (grant_dmem) begin
        dp_owner_reg <= OWNER_DMEM;
        streak_reg   <= streak_reg + 4'd1;
      end else if (grant_imem) begin
        dp_owner_reg <= OWNER_IMEM;
        streak_reg   <= 4'd0;
      end else begin
        dp_owner_reg <= OWNER_NONE;
      end
    end
  end

  assign imem_rdata    = mem_rdata;
  assign dmem_rdata    = mem_rdata;
  assign imem_wait     = ~((dp_owner_reg == OWNER_IMEM) & ~mem_wait);
  assign dmem_wait     = ((dp_owner_reg == OWNER_DMEM) & mem_wait) | dmem_deferred_reg;
  assign imem_badmem_e = mem_badmem_e & (dp_owner_reg == OWNER_IMEM) & ~mem_wait;
  assign dmem_badmem_e = mem_badmem_e & (dp_owner_reg == OWNER_DMEM) & ~mem_wait;
  assign mem_wdata     = ((dp_owner_reg == OWNER_DMEM) & dp_wen_reg) ? dmem_wdata_delayed : 32'h0;

endmodule
